// File: rtl/axi4_rd_burst_scheduler.sv
// Splits a byte-length read transfer into AXI4 INCR bursts that respect MAX_LEN_P
// and never cross a 4 KB page. Assumes ADDR_WIDTH_P >= 12.
module axi4_rd_burst_scheduler #(
  parameter int unsigned ID_WIDTH_P   = 4,
  parameter int unsigned ADDR_WIDTH_P = 32,
  parameter int unsigned DATA_WIDTH_P = 32,
  parameter int unsigned MAX_LEN_P    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH_P-1:0] cmd_addr,
  input  logic [31:0]             cmd_bytes,
  input  logic [ID_WIDTH_P-1:0]   cmd_id,
  output logic                    arvalid,
  input  logic                    arready,
  output logic [ADDR_WIDTH_P-1:0] araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [ID_WIDTH_P-1:0]   arid,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned BeatBytes = DATA_WIDTH_P / 8;
  localparam int unsigned SizeLog   = $clog2(BeatBytes);

  typedef enum logic [1:0] {StIdle, StCalc, StIssue, StDone} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH_P-1:0] addr_q;
  logic [32:0]             remaining_q;
  logic [32:0]             beats_q;
  logic [ID_WIDTH_P-1:0]   id_q;

  logic [ADDR_WIDTH_P-1:0] araddr_q;
  logic [7:0]              arlen_q;
  logic [2:0]              arsize_q;
  logic [1:0]              arburst_q;
  logic [ID_WIDTH_P-1:0]   arid_q;

  logic [ADDR_WIDTH_P-1:0] addr_aligned;
  logic [32:0]             cmd_beats;
  logic [12:0]             page_beats;
  logic [32:0]             beats_d;
  logic [32:0]             rem_after;
  logic [ADDR_WIDTH_P-1:0] addr_step;

  // 33-bit sum so cmd_bytes near 2^32 cannot overflow the round-up.
  assign cmd_beats    = ({1'b0, cmd_bytes} + 33'(BeatBytes - 1)) >> SizeLog;
  assign addr_aligned = cmd_addr & ~ADDR_WIDTH_P'(BeatBytes - 1);
  assign page_beats   = (13'd4096 - {1'b0, addr_q[11:0]}) >> SizeLog;
  assign rem_after    = remaining_q - beats_q;
  assign addr_step    = ADDR_WIDTH_P'(beats_q) << SizeLog;

  always_comb begin
    beats_d = remaining_q;
    if (beats_d > 33'(MAX_LEN_P)) begin
      beats_d = 33'(MAX_LEN_P);
    end
    if (beats_d > 33'(page_beats)) begin
      beats_d = 33'(page_beats);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    arvalid   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          state_d = StCalc;
        end
      end
      StCalc: begin
        state_d = (remaining_q == 33'd0) ? StDone : StIssue;
      end
      StIssue: begin
        arvalid = 1'b1;
        if (arready) begin
          state_d = (rem_after == 33'd0) ? StDone : StCalc;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      id_q        <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      arid_q      <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            addr_q      <= addr_aligned;
            remaining_q <= cmd_beats;
            id_q        <= cmd_id;
          end
        end
        StCalc: begin
          if (remaining_q != 33'd0) begin
            beats_q   <= beats_d;
            araddr_q  <= addr_q;
            arlen_q   <= 8'(beats_d - 33'd1);
            arsize_q  <= 3'(SizeLog);
            arburst_q <= 2'b01;
            arid_q    <= id_q;
          end
        end
        StIssue: begin
          if (arready) begin
            addr_q      <= addr_q + addr_step;
            remaining_q <= rem_after;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = arsize_q;
  assign arburst = arburst_q;
  assign arid    = arid_q;

endmodule

// File: tb/tb_axi4_rd_burst_scheduler.sv
// Directed bench for axi4_rd_burst_scheduler (32-bit data, 256-beat max bursts).
module tb_axi4_rd_burst_scheduler;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_bytes;
  logic [3:0]  cmd_id;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arid;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  axi4_rd_burst_scheduler #(
    .ID_WIDTH_P  (4),
    .ADDR_WIDTH_P(32),
    .DATA_WIDTH_P(32),
    .MAX_LEN_P   (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr (cmd_addr),
    .cmd_bytes(cmd_bytes),
    .cmd_id   (cmd_id),
    .arvalid  (arvalid),
    .arready  (arready),
    .araddr   (araddr),
    .arlen    (arlen),
    .arsize   (arsize),
    .arburst  (arburst),
    .arid     (arid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge (CALC).
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] id);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_bytes = b;
    cmd_id    = id;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Waits (bounded) for arvalid, checks the payload, then handshakes.
  task automatic ar_burst(input string tag, input logic [31:0] a, input logic [7:0] len,
                          input logic [3:0] id);
    int n = 0;
    while (!arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!arvalid) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "_araddr"}, 64'(araddr), 64'(a));
    check({tag, "_arlen"}, 64'(arlen), 64'(len));
    check({tag, "_arsize"}, 64'(arsize), 64'd2);
    check({tag, "_arburst"}, 64'(arburst), 64'd1);
    check({tag, "_arid"}, 64'(arid), 64'(id));
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_bytes = '0;
    cmd_id    = '0;
    arready   = 1'b0;

    @(negedge clk);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_arvalid", 64'(arvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_araddr", 64'(araddr), 64'd0);
    check("rst_arlen", 64'(arlen), 64'd0);
    check("rst_arsize", 64'(arsize), 64'd0);
    check("rst_arid", 64'(arid), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single 16-beat burst, with latency and done timing.
    send_cmd(32'h0000, 32'd64, 4'd1);
    check("t1_calc_arvalid", 64'(arvalid), 64'd0);
    check("t1_calc_busy", 64'(busy), 64'd1);
    check("t1_calc_cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("t1_latency_arvalid", 64'(arvalid), 64'd1);
    ar_burst("t1", 32'h0000, 8'd15, 4'd1);
    check("t1_done", 64'(done), 64'd1);
    check("t1_done_busy", 64'(busy), 64'd1);
    check("t1_done_arvalid", 64'(arvalid), 64'd0);
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // 4 KB boundary split with exactly one gap cycle.
    send_cmd(32'h0FF0, 32'd64, 4'd2);
    ar_burst("t2a", 32'h0FF0, 8'd3, 4'd2);
    check("t2_gap_arvalid", 64'(arvalid), 64'd0);
    check("t2_gap_done", 64'(done), 64'd0);
    @(negedge clk);
    check("t2_gap_end_arvalid", 64'(arvalid), 64'd1);
    ar_burst("t2b", 32'h1000, 8'd11, 4'd2);
    check("t2_done", 64'(done), 64'd1);
    @(negedge clk);

    // MAX_LEN split.
    send_cmd(32'h0000, 32'd2048, 4'd3);
    ar_burst("t3a", 32'h0000, 8'd255, 4'd3);
    ar_burst("t3b", 32'h0400, 8'd255, 4'd3);
    check("t3_done", 64'(done), 64'd1);
    @(negedge clk);

    // Unaligned address, partial beat round-up.
    send_cmd(32'h0006, 32'd6, 4'd4);
    ar_burst("t4a", 32'h0004, 8'd1, 4'd4);
    check("t4a_done", 64'(done), 64'd1);
    @(negedge clk);

    // Zero-length transfer.
    send_cmd(32'h0040, 32'd0, 4'd5);
    check("t4b_calc_done", 64'(done), 64'd0);
    @(negedge clk);
    check("t4b_done", 64'(done), 64'd1);
    check("t4b_arvalid", 64'(arvalid), 64'd0);
    @(negedge clk);
    check("t4b_idle_done", 64'(done), 64'd0);
    check("t4b_idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // Stall in ISSUE; arready while arvalid low is harmless; cmd_valid ignored.
    send_cmd(32'h0100, 32'd16, 4'd6);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    check("t5_issue_after_early_ready", 64'(arvalid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 32'h0800;
      cmd_bytes = 32'd4;
      cmd_id    = 4'd9;
      check("t5_hold_arvalid", 64'(arvalid), 64'd1);
      check("t5_hold_araddr", 64'(araddr), 64'h100);
      check("t5_hold_arlen", 64'(arlen), 64'd3);
      check("t5_hold_cmd_ready", 64'(cmd_ready), 64'd0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    ar_burst("t5", 32'h0100, 8'd3, 4'd6);
    check("t5_done", 64'(done), 64'd1);
    @(negedge clk);
    check("t5_idle_cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    check("t5_no_extra_arvalid", 64'(arvalid), 64'd0);
    check("t5_no_extra_busy", 64'(busy), 64'd0);

    // Reset while arvalid is high.
    send_cmd(32'h0200, 32'd64, 4'd7);
    @(negedge clk);
    check("t6_pre_arvalid", 64'(arvalid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_arvalid", 64'(arvalid), 64'd0);
    check("t6_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_araddr", 64'(araddr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_post_done", 64'(done), 64'd0);
      check("t6_post_arvalid", 64'(arvalid), 64'd0);
      check("t6_post_cmd_ready", 64'(cmd_ready), 64'd1);
    end

    // Normal operation after the discarded transfer.
    send_cmd(32'h0010, 32'd4, 4'd8);
    ar_burst("t7", 32'h0010, 8'd0, 4'd8);
    check("t7_done", 64'(done), 64'd1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
